// File: rtl/dmem_stage.sv
// -----------------------------------------------------------------------------
// dmem_stage
// Data-memory stage for the CPU MEM pipeline stage. A single-port synchronous
// RAM serves byte/half/word(/dword) loads and stores. It uses byte addressing,
// little-endian lanes and sign/zero extension, and it flags misaligned
// accesses. An optional clear sequence zeroes the whole array after reset.
// Every accepted request produces exactly one response on the next cycle.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high. The response side has no backpressure. rsp_valid
// pulses for one cycle, on the cycle after the accept. rsp_data and rsp_err
// hold their last values while rsp_valid is low.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready is low during reset and clear)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 dword (64-bit only)
//   req_signed        loads: 1 sign-extend, 0 zero-extend
//   req_addr          byte address {word index, lane offset}
//   req_wdata         right-justified store data
//   rsp_valid         one-cycle response pulse
//   rsp_data          extended load result; 0 for stores and errors
//   rsp_err           misaligned or illegal size (no memory effect)
// -----------------------------------------------------------------------------
module dmem_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int INIT_ZERO = 1,
  localparam int LANES    = DATA_W / 8,
  localparam int OFF_W    = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_W+OFF_W-1:0] req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  // Kept as a named, typed signal so the FSM state is visible for debug.
  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_q;

  // Request decode
  logic                accept;
  logic [ADDR_W-1:0]   word_idx;
  logic [OFF_W-1:0]    lane_off;
  logic [2:0]          off3;
  logic                bad;
  logic [LANES-1:0]    lane_mask;
  logic [DATA_W-1:0]   wrep;
  logic                st_we;
  logic                ld_en;

  // Fields captured at accept, used to shape the load response
  logic                cap_load;
  logic [OFF_W-1:0]    cap_off;
  logic [1:0]          cap_size;
  logic                cap_signed;

  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[ADDR_W+OFF_W-1:OFF_W];
  assign lane_off = req_addr[OFF_W-1:0];
  assign off3     = 3'(lane_off);

  always_comb begin
    bad = 1'b0;
    case (req_size)
      2'b01:   bad = off3[0];
      2'b10:   bad = |off3[1:0];
      2'b11:   bad = (DATA_W == 32) ? 1'b1 : |off3;
      default: bad = 1'b0;
    endcase
  end

  // Lanes [off, off + size_bytes) are written.
  always_comb begin
    int nbytes;
    nbytes    = 1 << req_size;
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = (i >= int'(lane_off)) && (i < int'(lane_off) + nbytes);
    end
  end

  // Store data is replicated across the word so each lane sees its own byte.
  always_comb begin
    wrep = req_wdata;
    case (req_size)
      2'b00:   wrep = {LANES{req_wdata[7:0]}};
      2'b01:   wrep = {(LANES / 2){req_wdata[15:0]}};
      2'b10:   wrep = {(LANES / 4){req_wdata[31:0]}};
      default: wrep = req_wdata;
    endcase
  end

  assign st_we = accept & req_we & ~bad;
  assign ld_en = accept & ~req_we & ~bad;

  // Control FSM and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      clr_cnt    <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      cap_load   <= 1'b0;
      cap_off    <= '0;
      cap_size   <= '0;
      cap_signed <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          req_ready <= 1'b0;
          clr_cnt   <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_RUN;
            req_ready <= 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
        end
      endcase

      rsp_valid <= accept;
      if (accept) begin
        rsp_err    <= bad;
        cap_load   <= ld_en;
        cap_off    <= lane_off;
        cap_size   <= req_size;
        cap_signed <= req_signed;
      end
    end
  end

  // RAM: the clear sequence and stores share the single write port. They
  // never collide, because req_ready is low for the whole clear.
  always_ff @(posedge clk) begin
    if (rst_n && state == ST_INIT) begin
      mem[clr_cnt] <= '0;
    end else if (st_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_mask[i]) mem[word_idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
    // The read register only moves on a load accept, so the response data
    // holds between responses.
    if (ld_en) rd_q <= mem[word_idx];
  end

  // Response shaping: shift the selected lanes to bit 0, then extend.
  always_comb begin
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ext;
    int                nbits;
    shifted = rd_q >> {cap_off, 3'b000};
    nbits   = 8 << cap_size;
    if (nbits > DATA_W) nbits = DATA_W;
    ext = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ext[i] = (i < nbits) ? shifted[i] : (cap_signed & shifted[nbits-1]);
    end
    rsp_data = cap_load ? ext : '0;
  end

endmodule

// File: tb/tb_dmem_stage.sv
// -----------------------------------------------------------------------------
// tb_dmem_stage
// Directed bench for dmem_stage (DATA_W=32, ADDR_W=10, INIT_ZERO=1).
// Inputs are driven on the falling edge, so the DUT accepts on the following
// rising edge. Outputs are checked at the next falling edge, which falls in
// the response cycle.
// -----------------------------------------------------------------------------
module tb_dmem_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int AW     = ADDR_W + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  dmem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_ZERO(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [AW-1:0] addr, input logic [DATA_W-1:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // Call at a falling edge right after reset release. Counts the falling-edge
  // samples (including the release point) that see req_ready low.
  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b data=%h required 0/0/0/00000000",
               req_ready, rsp_valid, rsp_err, rsp_data);
    end
  endtask

  task automatic test_init_and_first_load();
    int n;
    rst_n = 1'b1;
    wait_ready(n);
    tests_run++;
    if (n !== 1024) begin
      tests_failed++;
      $display("FAIL init_ready_low_cycles: got %0d required 1024", n);
    end
    drive_req(1'b0, 2'b10, 1'b0, 12'h030, '0);
    @(negedge clk);
    drive_idle();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL init_load_zero: got valid=%b err=%b data=%h required 1/0/00000000",
               rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsp_pulse_width: got valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_store_then_load();
    drive_req(1'b1, 2'b10, 1'b0, 12'h030, 32'hDEAD_BEEF);
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL store_word_rsp: got valid=%b err=%b data=%h required 1/0/00000000",
               rsp_valid, rsp_err, rsp_data);
    end
    drive_req(1'b0, 2'b10, 1'b0, 12'h030, '0);
    @(negedge clk);
    drive_idle();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL load_after_store: got valid=%b data=%h required 1/deadbeef",
               rsp_valid, rsp_data);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL rsp_hold: got valid=%b data=%h required 0/deadbeef", rsp_valid, rsp_data);
    end
  endtask

  // Back-to-back sub-word loads from the word 0xDEADBEEF.
  task automatic test_back_to_back_extend();
    logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] ad  [4] = '{12'h031, 12'h031, 12'h032, 12'h030};
    logic [31:0] exp [4] = '{32'hFFFF_FFBE, 32'h0000_00BE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    drive_req(1'b0, sz[0], sg[0], ad[0], '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) drive_req(1'b0, sz[i+1], sg[i+1], ad[i+1], '0);
      else drive_idle();
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== exp[i]) begin
        tests_failed++;
        $display("FAIL extend_load_%0d: got valid=%b err=%b data=%h required 1/0/%h",
                 i, rsp_valid, rsp_err, rsp_data, exp[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_partial_stores();
    drive_req(1'b1, 2'b00, 1'b0, 12'h033, 32'h0000_0055);
    @(negedge clk);
    drive_req(1'b1, 2'b01, 1'b0, 12'h030, 32'h0000_1234);
    @(negedge clk);
    drive_req(1'b0, 2'b10, 1'b0, 12'h030, '0);
    @(negedge clk);
    drive_idle();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h55AD_1234) begin
      tests_failed++;
      $display("FAIL partial_store_merge: got valid=%b data=%h required 1/55ad1234",
               rsp_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    drive_req(1'b0, 2'b10, 1'b0, 12'h031, '0);
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL misaligned_load: got valid=%b err=%b data=%h required 1/1/00000000",
               rsp_valid, rsp_err, rsp_data);
    end
    drive_req(1'b1, 2'b01, 1'b0, 12'h033, 32'h0000_FFFF);
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL misaligned_store: got valid=%b err=%b data=%h required 1/1/00000000",
               rsp_valid, rsp_err, rsp_data);
    end
    drive_req(1'b0, 2'b10, 1'b0, 12'h030, '0);
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h55AD_1234) begin
      tests_failed++;
      $display("FAIL no_write_on_err: got valid=%b err=%b data=%h required 1/0/55ad1234",
               rsp_valid, rsp_err, rsp_data);
    end
    drive_req(1'b0, 2'b11, 1'b0, 12'h030, '0);
    @(negedge clk);
    drive_idle();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL illegal_size: got valid=%b err=%b data=%h required 1/1/00000000",
               rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_init();
    int n;
    // Reset in RUN to start a fresh clear, then interrupt it at cycle 500.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_init_outputs: got ready=%b valid=%b err=%b data=%h required zeros",
               req_ready, rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    tests_run++;
    if (n !== 1024) begin
      tests_failed++;
      $display("FAIL reinit_ready_low_cycles: got %0d required 1024", n);
    end
  endtask

  task automatic test_reset_mid_stream();
    int n;
    int stale;
    drive_req(1'b1, 2'b10, 1'b0, 12'h040, 32'hCAFE_F00D);
    @(negedge clk);
    drive_req(1'b0, 2'b10, 1'b0, 12'h040, '0);
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL stream_load_before_reset: got valid=%b data=%h required 1/cafef00d",
               rsp_valid, rsp_data);
    end
    // Another load keeps the stream going, then reset hits mid-response.
    @(posedge clk);
    #2;
    drive_req(1'b1, 2'b10, 1'b0, 12'h044, 32'h1111_1111);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_stream_outputs: got valid=%b ready=%b data=%h err=%b required 0/0/00000000/0",
               rsp_valid, req_ready, rsp_data, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    n = 0;
    while (!req_ready && n < 2000) begin
      if (rsp_valid !== 1'b0) stale++;
      n++;
      @(negedge clk);
    end
    drive_idle();
    tests_run++;
    if (n !== 1024 || stale !== 0) begin
      tests_failed++;
      $display("FAIL reinit_after_stream: got low_cycles=%0d stale_valid=%0d required 1024/0",
               n, stale);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_stale_rsp_after_init: got valid=%b required 0", rsp_valid);
    end
    drive_req(1'b0, 2'b10, 1'b0, 12'h044, '0);
    @(negedge clk);
    drive_idle();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL cleared_after_reinit: got valid=%b data=%h required 1/00000000",
               rsp_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init_and_first_load();
    test_store_then_load();
    test_back_to_back_extend();
    test_partial_stores();
    test_misaligned();
    test_reset_mid_init();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
